// File: rtl/i2s_rx_deserializer_pkg.sv
// Shared definitions for the I2S receive path: FSM states, channel codes,
// default word/slot geometry.
package i2s_pkg;

   localparam int SAMPLE_WIDTH_DEF = 24;
   localparam int SLOT_WIDTH_DEF   = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SKIP  = 2'd1,
      SHIFT = 2'd2,
      PAD   = 2'd3
   } state_t;

   localparam logic CH_L = 1'b0;
   localparam logic CH_R = 1'b1;

endpackage

// File: rtl/i2s_rx_deserializer_if.sv
// Edge-pulse inputs and parallel sample outputs of the I2S deserializer.
// master = the side producing edge pulses (and consuming samples),
// slave  = the deserializer itself.
interface i2s_rx_deserializer_if
   import i2s_pkg::*;
#(
   parameter int SAMPLE_WIDTH = SAMPLE_WIDTH_DEF
);
   logic                    bclk_rise;
   logic                    lrclk_rise;
   logic                    lrclk_fall;
   logic                    sdata;
   logic [SAMPLE_WIDTH-1:0] left_sample;
   logic [SAMPLE_WIDTH-1:0] right_sample;
   logic                    sample_valid;
   logic                    frame_err;

   modport master (
      output bclk_rise, lrclk_rise, lrclk_fall, sdata,
      input  left_sample, right_sample, sample_valid, frame_err
   );

   modport slave (
      input  bclk_rise, lrclk_rise, lrclk_fall, sdata,
      output left_sample, right_sample, sample_valid, frame_err
   );
endinterface

// File: rtl/i2s_rx_deserializer_slot_shifter.sv
// Per-slot shift register and bit counter. word_nxt is the word including
// the bit on sdata this cycle, so the FSM can commit it on the LSB edge.
module i2s_slot_shifter
   import i2s_pkg::*;
#(
   parameter int SAMPLE_WIDTH = SAMPLE_WIDTH_DEF,
   parameter int SLOT_WIDTH   = SLOT_WIDTH_DEF,
   localparam int CNT_W       = $clog2(SLOT_WIDTH + 1)
) (
   input  logic                    fast_clk,
   input  logic                    rst,
   input  logic                    clr,
   input  logic                    en,
   input  logic                    sdata,
   output logic [SAMPLE_WIDTH-1:0] word_nxt,
   output logic [CNT_W-1:0]        bit_cnt
);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SLOT_WIDTH);

   // Only SAMPLE_WIDTH-1 bits are stored; the newest bit comes straight from sdata.
   logic [SAMPLE_WIDTH-2:0] shreg;

   assign word_nxt = {shreg, sdata};

   // Clear at slot start; shift and count (saturating) on each enabled bit.
   always_ff @(posedge fast_clk) begin
      if (rst || clr) begin
         shreg   <= '0;
         bit_cnt <= '0;
      end else if (en) begin
         shreg <= word_nxt[SAMPLE_WIDTH-2:0];
         if (bit_cnt != CNT_MAX) bit_cnt <= bit_cnt + 1'b1;
      end
   end
endmodule

// File: rtl/i2s_rx_deserializer.sv
// Philips I2S frame deserializer. Works on single-cycle BCLK/LRCLK edge
// pulses in the fast_clk domain and emits signed L/R pairs, left first.
module i2s_rx_deserializer
   import i2s_pkg::*;
#(
   parameter int SAMPLE_WIDTH = SAMPLE_WIDTH_DEF,
   parameter int SLOT_WIDTH   = SLOT_WIDTH_DEF
) (
   input logic                  fast_clk,
   input logic                  rst,
   i2s_rx_deserializer_if.slave bus
);
   localparam int CNT_W = $clog2(SLOT_WIDTH + 1);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(SAMPLE_WIDTH - 1);
   // bit_cnt value after the final legal bclk_rise of a slot (SKIP is bit 0).
   localparam logic [CNT_W-1:0] PAD_LAST = CNT_W'(SLOT_WIDTH - 1);

   state_t                  state, state_nxt;
   logic                    chan, chan_nxt;
   logic                    sh_clr, sh_en;
   logic                    commit_l, commit_r, drop, err_nxt;
   logic [SAMPLE_WIDTH-1:0] word_nxt;
   logic [CNT_W-1:0]        bit_cnt;

   logic [SAMPLE_WIDTH-1:0] left_hold, left_q, right_q;
   logic                    left_pend, valid_q, err_q;

   logic lr_any, edge_bad;

   assign lr_any   = bus.lrclk_rise | bus.lrclk_fall;
   // Both edges at once, or an edge that repeats the current channel.
   assign edge_bad = (bus.lrclk_rise & bus.lrclk_fall) |
                     (bus.lrclk_rise & (chan == CH_R)) |
                     (bus.lrclk_fall & (chan == CH_L));

   i2s_slot_shifter #(
      .SAMPLE_WIDTH (SAMPLE_WIDTH),
      .SLOT_WIDTH   (SLOT_WIDTH)
   ) u_shifter (
      .fast_clk (fast_clk),
      .rst      (rst),
      .clr      (sh_clr),
      .en       (sh_en),
      .sdata    (bus.sdata),
      .word_nxt (word_nxt),
      .bit_cnt  (bit_cnt)
   );

   // State and current-channel registers.
   always_ff @(posedge fast_clk) begin
      if (rst) begin
         state <= IDLE;
         chan  <= CH_L;
      end else begin
         state <= state_nxt;
         chan  <= chan_nxt;
      end
   end

   // Next state, shifter control and commit/error strobes. An LRCLK edge takes
   // priority over a coincident bclk_rise, which is then the slot's skip bit.
   always_comb begin
      state_nxt = state;
      chan_nxt  = chan;
      sh_clr    = 1'b0;
      sh_en     = 1'b0;
      commit_l  = 1'b0;
      commit_r  = 1'b0;
      drop      = 1'b0;
      err_nxt   = 1'b0;
      case (state)
         IDLE: begin
            if (bus.lrclk_fall && !bus.lrclk_rise) begin
               chan_nxt  = CH_L;
               sh_clr    = 1'b1;
               drop      = 1'b1;
               state_nxt = bus.bclk_rise ? SHIFT : SKIP;
            end
         end
         default: begin
            if (lr_any) begin
               if (edge_bad) begin
                  err_nxt   = 1'b1;
                  drop      = 1'b1;
                  state_nxt = IDLE;
               end else begin
                  // Leaving before the word completed is a short slot.
                  if (state != PAD) begin
                     err_nxt = 1'b1;
                     drop    = 1'b1;
                  end
                  chan_nxt  = bus.lrclk_rise ? CH_R : CH_L;
                  sh_clr    = 1'b1;
                  state_nxt = bus.bclk_rise ? SHIFT : SKIP;
               end
            end else if (bus.bclk_rise) begin
               case (state)
                  SKIP: begin
                     sh_clr    = 1'b1;
                     state_nxt = SHIFT;
                  end
                  SHIFT: begin
                     sh_en = 1'b1;
                     if (bit_cnt == LAST_BIT) begin
                        state_nxt = PAD;
                        commit_l  = (chan == CH_L);
                        commit_r  = (chan == CH_R);
                     end
                  end
                  default: begin
                     if (bit_cnt >= PAD_LAST) begin
                        err_nxt   = 1'b1;
                        drop      = 1'b1;
                        state_nxt = IDLE;
                     end else begin
                        sh_en = 1'b1;
                     end
                  end
               endcase
            end
         end
      endcase
   end

   // Left word is held until its right partner lands; pair and pulses register here.
   always_ff @(posedge fast_clk) begin
      if (rst) begin
         left_hold <= '0;
         left_pend <= 1'b0;
         left_q    <= '0;
         right_q   <= '0;
         valid_q   <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         valid_q <= commit_r & left_pend;
         err_q   <= err_nxt;
         if (commit_l) begin
            left_hold <= word_nxt;
            left_pend <= 1'b1;
         end else if (drop || commit_r) begin
            left_pend <= 1'b0;
         end
         if (commit_r && left_pend) begin
            left_q  <= left_hold;
            right_q <= word_nxt;
         end
      end
   end

   assign bus.left_sample  = left_q;
   assign bus.right_sample = right_q;
   assign bus.sample_valid = valid_q;
   assign bus.frame_err    = err_q;
endmodule
